// File: rtl/pretrig_test_sequencer.sv
// Test-pulse scheduler for the pre-trigger front end.
// Issues single or paired test pulses, periodic or armed single-shot, and holds off while the datapath is busy.
module pretrig_test_sequencer #(
    parameter int unsigned SIZE_DELAY  = 8,
    parameter int unsigned SIZE_PERIOD = 16,
    parameter int unsigned PULSE_WIDTH = 4,
    parameter int unsigned SIZE_CNT    = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   enable_i,
    input  logic                   test_rate_i,
    input  logic                   test_overlay_i,
    input  logic [SIZE_DELAY-1:0]  test_delay_i,
    input  logic [SIZE_PERIOD-1:0] period_i,
    input  logic                   arm_i,
    input  logic                   trig_busy_i,
    output logic                   test_pulse_o,
    output logic                   test_active_o,
    output logic                   seq_done_o,
    output logic [SIZE_CNT-1:0]    pulse_cnt_o
);

    localparam int unsigned PW_W = $clog2(PULSE_WIDTH + 1);
    localparam int unsigned PH_W = (PW_W > SIZE_DELAY) ? PW_W : SIZE_DELAY;
    localparam logic [PH_W-1:0] PW_LAST = PH_W'(PULSE_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ARB,
        S_FIRE1,
        S_GAP,
        S_FIRE2,
        S_END
    } state_t;

    state_t                   state_q;
    logic [SIZE_PERIOD-1:0]   wait_cnt_q;
    logic [PH_W-1:0]          ph_cnt_q;
    logic                     ovl_q;
    logic [SIZE_DELAY-1:0]    dly_q;
    logic                     arm_prev_q;
    logic                     test_pulse_q;
    logic                     test_active_q;
    logic                     seq_done_q;
    logic [SIZE_CNT-1:0]      pulse_cnt_q;

    logic                     arm_rise;
    logic [SIZE_PERIOD-1:0]   period_last;
    logic [PH_W-1:0]          gap_last;

    // A period of zero behaves as a one-cycle wait.
    assign arm_rise    = arm_i & ~arm_prev_q;
    assign period_last = (period_i == '0) ? '0 : period_i - SIZE_PERIOD'(1);
    assign gap_last    = PH_W'(dly_q) - PH_W'(1);

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q       <= S_IDLE;
            wait_cnt_q    <= '0;
            ph_cnt_q      <= '0;
            ovl_q         <= 1'b0;
            dly_q         <= '0;
            arm_prev_q    <= 1'b0;
            test_pulse_q  <= 1'b0;
            test_active_q <= 1'b0;
            seq_done_q    <= 1'b0;
            pulse_cnt_q   <= '0;
        end else begin
            arm_prev_q <= arm_i;
            seq_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (enable_i && test_rate_i) begin
                        state_q       <= S_WAIT;
                        wait_cnt_q    <= '0;
                        test_active_q <= 1'b1;
                    end else if (enable_i && arm_rise) begin
                        state_q       <= S_ARB;
                        test_active_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (!enable_i) begin
                        state_q       <= S_IDLE;
                        test_active_q <= 1'b0;
                    end else if (wait_cnt_q == period_last) begin
                        state_q <= S_ARB;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + SIZE_PERIOD'(1);
                    end
                end
                S_ARB: begin
                    if (!enable_i) begin
                        state_q       <= S_IDLE;
                        test_active_q <= 1'b0;
                    end else if (!trig_busy_i) begin
                        state_q      <= S_FIRE1;
                        ovl_q        <= test_overlay_i;
                        dly_q        <= test_delay_i;
                        ph_cnt_q     <= '0;
                        test_pulse_q <= 1'b1;
                        pulse_cnt_q  <= pulse_cnt_q + SIZE_CNT'(1);
                    end
                end
                // Zero gap chains straight into FIRE2 for one merged high interval.
                S_FIRE1: begin
                    if (ph_cnt_q == PW_LAST) begin
                        ph_cnt_q <= '0;
                        if (!ovl_q) begin
                            state_q      <= S_END;
                            test_pulse_q <= 1'b0;
                            seq_done_q   <= 1'b1;
                        end else if (dly_q == '0) begin
                            state_q     <= S_FIRE2;
                            pulse_cnt_q <= pulse_cnt_q + SIZE_CNT'(1);
                        end else begin
                            state_q      <= S_GAP;
                            test_pulse_q <= 1'b0;
                        end
                    end else begin
                        ph_cnt_q <= ph_cnt_q + PH_W'(1);
                    end
                end
                S_GAP: begin
                    if (ph_cnt_q == gap_last) begin
                        state_q      <= S_FIRE2;
                        ph_cnt_q     <= '0;
                        test_pulse_q <= 1'b1;
                        pulse_cnt_q  <= pulse_cnt_q + SIZE_CNT'(1);
                    end else begin
                        ph_cnt_q <= ph_cnt_q + PH_W'(1);
                    end
                end
                S_FIRE2: begin
                    if (ph_cnt_q == PW_LAST) begin
                        state_q      <= S_END;
                        ph_cnt_q     <= '0;
                        test_pulse_q <= 1'b0;
                        seq_done_q   <= 1'b1;
                    end else begin
                        ph_cnt_q <= ph_cnt_q + PH_W'(1);
                    end
                end
                S_END: begin
                    if (enable_i && test_rate_i) begin
                        state_q    <= S_WAIT;
                        wait_cnt_q <= '0;
                    end else begin
                        state_q       <= S_IDLE;
                        test_active_q <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= S_IDLE;
                    test_pulse_q  <= 1'b0;
                    test_active_q <= 1'b0;
                end
            endcase
        end
    end

    assign test_pulse_o  = test_pulse_q;
    assign test_active_o = test_active_q;
    assign seq_done_o    = seq_done_q;
    assign pulse_cnt_o   = pulse_cnt_q;

endmodule

// File: doc/pretrig_test_sequencer.md
# pretrig_test_sequencer

Test-pulse scheduler for the pre-trigger datapath. It decides when test pulses are injected into the pre-trigger front end, single or paired (overlay, for pile-up checks), periodic or single-shot. It never injects while the pre-trigger datapath reports busy. It sits beside the pre-trigger core and drives its test-injection input, using the same test_overlay / test_rate / test_delay configuration.

## Interface
Parameters:
- SIZE_DELAY, 8, width of test_delay (gap between paired pulses, in clk cycles)
- SIZE_PERIOD, 16, width of period
- PULSE_WIDTH, 4, high time of each test pulse in clk cycles (≥1)
- SIZE_CNT, 16, width of pulse_cnt

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- enable  in  1  master enable for test injection
- test_rate  in  1  1 = periodic injection, 0 = single-shot on arm
- test_overlay  in  1  1 = paired pulses (second pulse after test_delay gap)
- test_delay  in  SIZE_DELAY  gap between end of pulse 1 and start of pulse 2
- period  in  SIZE_PERIOD  WAIT duration in cycles; 0 treated as 1
- arm  in  1  single-shot request; rising edge detected internally
- trig_busy  in  1  pre-trigger datapath busy; injection held off while 1
- test_pulse  out  1  injection pulse to the pre-trigger core (registered)
- test_active  out  1  sequencer not in IDLE
- seq_done  out  1  one-cycle strobe at end of each sequence
- pulse_cnt  out  SIZE_CNT  count of pulses issued, wraps modulo 2^SIZE_CNT

## Operation
- The FSM has the states IDLE, WAIT, ARB, FIRE1, GAP, FIRE2, END.
- IDLE:
  - enable=1 and test_rate=1 → WAIT, with the period counter cleared.
  - enable=1, test_rate=0 and an arm rising edge (arm=1 while the registered arm_d=0) → ARB.
- WAIT: the counter increments every cycle. When counter = period_eff-1 → ARB. period_eff = max(period,1). period is sampled live.
- ARB:
  - trig_busy=0 → FIRE1. On this transition, test_overlay and test_delay are latched (ovl_l, dly_l).
  - trig_busy=1 → stay in ARB, indefinitely.
- FIRE1: test_pulse=1 for PULSE_WIDTH cycles. Then:
  - ovl_l=0 → END.
  - ovl_l=1 and dly_l=0 → FIRE2 directly, giving one merged high interval of 2×PULSE_WIDTH.
  - otherwise → GAP.
- GAP: test_pulse=0 for dly_l cycles → FIRE2. trig_busy is ignored once the sequence has started.
- FIRE2: test_pulse=1 for PULSE_WIDTH cycles → END.
- END: seq_done=1 for one cycle. Then → WAIT (counter cleared) if enable=1 and test_rate=1, else → IDLE.
- Deasserting enable mid-sequence (FIRE1/GAP/FIRE2) does not truncate pulses. The sequence completes and END returns to IDLE.
- Deasserting enable in WAIT or ARB → IDLE on the next cycle, with no pulse issued.
- Changing test_overlay or test_delay mid-sequence has no effect until the next ARB→FIRE1 transition.
- pulse_cnt increments by 1 on entry to FIRE1 and on entry to FIRE2. It wraps all-ones → 0 with no flag.
- Arm edges seen outside IDLE are ignored and not queued.
- test_pulse and test_active are decoded from the registered state. test_pulse is high exactly in FIRE1/FIRE2.

## Timing
- Reset (reset=0 at a clk edge), from the next cycle:
  - state = IDLE
  - test_pulse = 0, test_active = 0, seq_done = 0, pulse_cnt = 0
  - all counters = 0, arm_d = 0
  - This applies in any state, including mid-pulse.
- ARB with trig_busy=0 at cycle n → test_pulse high for cycles n+1 … n+PULSE_WIDTH.
- Arm rising edge sampled at cycle n in IDLE, not busy → ARB at n+1, test_pulse high from n+2.
- Periodic cadence with no busy and overlay=0: WAIT period_eff + ARB 1 + FIRE1 PULSE_WIDTH + END 1. Pulse repetition = period_eff+PULSE_WIDTH+2 cycles.
- Overlay adds dly_l+PULSE_WIDTH cycles per sequence.
- seq_done is asserted in the cycle after the last test_pulse high cycle.
- test_active goes high the cycle after leaving IDLE and low the cycle after returning to IDLE.

## Test plan
- Periodic single: PULSE_WIDTH=4, period=10, test_rate=1, overlay=0, busy=0 → test_pulse high 4 cycles every 16 cycles; pulse_cnt 1,2,3… ; seq_done 1 cycle after each pulse.
- Overlay gap: overlay=1, test_delay=3 → pattern 4 high, 3 low, 4 high; pulse_cnt +2 per sequence. With test_delay=0 → one 8-cycle high; pulse_cnt +2.
- Busy hold-off: trig_busy=1 for 20 cycles, starting before WAIT expiry → FSM stays in ARB and test_pulse stays 0. First pulse starts exactly 1 cycle after trig_busy falls. Busy asserted during GAP → second pulse still issued on schedule.
- Single-shot: test_rate=0, arm 0→1 held 10 cycles → exactly one sequence, first high 2 cycles after the edge. No second sequence until arm is low then high again.
- Reset/enable mid-operation: reset=0 in the 2nd FIRE1 cycle → test_pulse=0 and pulse_cnt=0 the next cycle. enable=0 in the 2nd FIRE1 cycle → the full 4-cycle pulse completes, then IDLE. enable=0 in WAIT → IDLE, no pulse.
- Wrap: SIZE_CNT=4, 17 pulses → pulse_cnt sequence …,15,0,1.
